// File: rtl/saes_pkg.sv
// Shared S-AES constants for the key schedule: the nibble S-box, the round
// constants and the key-expansion FSM states.
package saes_pkg;

  // The entry for nibble index i sits in bits [4*i+3 : 4*i].
  localparam logic [63:0] SBOX_TABLE = 64'h7FEC_3026_581D_BA49;

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND1 = 2'd1,
    RND2 = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    return SBOX_TABLE[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] rot_nib(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

endpackage

// File: rtl/sub_nibble.sv
// Applies the S-AES S-box to each nibble of a byte independently.
module sub_nibble
  import saes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nib
      assign dout[gi*4 +: 4] = sbox(din[gi*4 +: 4]);
    end
  endgenerate

endmodule

// File: rtl/key_expansion.sv
// S-AES key schedule: one round key per cycle through a single shared
// nibble-substitution unit, 2 cycles from the accepting edge.
module key_expansion
  import saes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cipher_key,
  output logic        ready,
  output logic [15:0] key0,
  output logic [15:0] key1,
  output logic [15:0] key2,
  output logic        keys_valid
);

  state_t      state_reg, state_next;
  logic [15:0] key0_reg, key0_next;
  logic [15:0] key1_reg, key1_next;
  logic [15:0] key2_reg, key2_next;
  logic        valid_reg, valid_next;

  logic [7:0]  sub_in, sub_out;
  logic [7:0]  w_even, w_odd;

  // RND1 derives {w2,w3} from {w0,w1}; RND2 derives {w4,w5} from {w2,w3}.
  assign sub_in = (state_reg == RND1) ? rot_nib(key0_reg[7:0]) : rot_nib(key1_reg[7:0]);

  sub_nibble u_sub_nibble (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    w_even = 8'h00;
    w_odd  = 8'h00;
    if (state_reg == RND1) begin
      w_even = key0_reg[15:8] ^ RCON1 ^ sub_out;
      w_odd  = w_even ^ key0_reg[7:0];
    end else begin
      w_even = key1_reg[15:8] ^ RCON2 ^ sub_out;
      w_odd  = w_even ^ key1_reg[7:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    key0_next  = key0_reg;
    key1_next  = key1_reg;
    key2_next  = key2_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          key0_next  = cipher_key;
          valid_next = 1'b0;
          state_next = RND1;
        end
      end
      RND1: begin
        key1_next  = {w_even, w_odd};
        state_next = RND2;
      end
      RND2: begin
        key2_next  = {w_even, w_odd};
        valid_next = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key0_reg  <= 16'h0000;
      key1_reg  <= 16'h0000;
      key2_reg  <= 16'h0000;
      valid_reg <= 1'b0;
    end else begin
      key0_reg  <= key0_next;
      key1_reg  <= key1_next;
      key2_reg  <= key2_next;
      valid_reg <= valid_next;
    end
  end

  assign ready      = (state_reg == IDLE) || (state_reg == DONE);
  assign key0       = key0_reg;
  assign key1       = key1_reg;
  assign key2       = key2_reg;
  assign keys_valid = valid_reg;

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion with hand-computed S-AES round keys.
module tb_key_expansion;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cipher_key;
  logic        ready;
  logic [15:0] key0;
  logic [15:0] key1;
  logic [15:0] key2;
  logic        keys_valid;

  int checks = 0;
  int errors = 0;

  key_expansion dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_key (cipher_key),
    .ready      (ready),
    .key0       (key0),
    .key1       (key1),
    .key2       (key2),
    .keys_valid (keys_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_keys(input string tag, input logic [15:0] k0, input logic [15:0] k1,
                            input logic [15:0] k2, input logic v, input logic r);
    check({tag, ".key0"}, key0, k0);
    check({tag, ".key1"}, key1, k1);
    check({tag, ".key2"}, key2, k2);
    check({tag, ".valid"}, {15'd0, keys_valid}, {15'd0, v});
    check({tag, ".ready"}, {15'd0, ready}, {15'd0, r});
    $display("txn %s: key0=%h key1=%h key2=%h valid=%b ready=%b", tag, key0, key1, key2, keys_valid, ready);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cipher_key = 16'h0000;
    step();
    step();
    rst = 1'b0;
    check_keys("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // 4AF5: per-cycle latency profile
    cipher_key = 16'h4AF5;
    start = 1'b1;
    step();
    start = 1'b0;
    check_keys("4af5_e0", 16'h4AF5, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    check_keys("4af5_e1", 16'h4AF5, 16'hDD28, 16'h0000, 1'b0, 1'b0);
    step();
    check_keys("4af5_e2", 16'h4AF5, 16'hDD28, 16'h87AF, 1'b1, 1'b1);
    step();
    step();
    check_keys("4af5_hold", 16'h4AF5, 16'hDD28, 16'h87AF, 1'b1, 1'b1);

    // A73B restarted from DONE
    cipher_key = 16'hA73B;
    start = 1'b1;
    step();
    start = 1'b0;
    check_keys("a73b_e0", 16'hA73B, 16'hDD28, 16'h87AF, 1'b0, 1'b0);
    step();
    check_keys("a73b_e1", 16'hA73B, 16'h1C27, 16'h87AF, 1'b0, 1'b0);
    step();
    check_keys("a73b_e2", 16'hA73B, 16'h1C27, 16'h7651, 1'b1, 1'b1);

    // start during RND1 is ignored
    cipher_key = 16'h4AF5;
    start = 1'b1;
    step();
    cipher_key = 16'hA73B;
    step();
    start = 1'b0;
    step();
    check_keys("ignore_busy", 16'h4AF5, 16'hDD28, 16'h87AF, 1'b1, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_keys("restart_e0", 16'hA73B, 16'hDD28, 16'h87AF, 1'b0, 1'b0);
    step();
    step();
    check_keys("restart_e2", 16'hA73B, 16'h1C27, 16'h7651, 1'b1, 1'b1);

    // reset during RND2 aborts
    cipher_key = 16'h4AF5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_keys("abort_rnd2", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_keys("after_abort", 16'h4AF5, 16'hDD28, 16'h87AF, 1'b1, 1'b1);

    // rst wins over start
    cipher_key = 16'hA73B;
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check_keys("rst_start", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step();
    step();
    check_keys("rst_no_run", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // 0000: all round-key bits come from RCON and S-box(0); key changes after accept
    cipher_key = 16'h0000;
    start = 1'b1;
    step();
    start = 1'b0;
    cipher_key = 16'hFFFF;
    step();
    cipher_key = 16'h5A5A;
    step();
    check_keys("k0000", 16'h0000, 16'h1919, 16'h0D14, 1'b1, 1'b1);

    cipher_key = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    cipher_key = 16'h1234;
    step();
    step();
    check_keys("kffff", 16'hFFFF, 16'h08F7, 16'h6F98, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
